mcycle_unit: RTL and testbench

Iterative multi-cycle RV32M multiply/divide unit in the Execute stage. Consumes the operand values and `Funct3E` delivered by the Execute pipeline registers. Drives `MCycleBusy`, which freezes the Fetch/Decode/Execute pipeline registers while an operation is in flight. Returns a single 32-bit result for the writeback path.

---
 rtl/mcycle_pkg.sv | 34 +++
 rtl/mcycle_sign_fix.sv | 40 ++++
 rtl/mcycle_unit.sv | 174 +++++++++++++++++
 tb/tb_mcycle_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// Shared encodings and helpers for the iterative RV32M multiply/divide unit.
package mcycle_pkg;

    // Funct3 encodings of the M-extension operations
    localparam logic [2:0] MC_MUL    = 3'b000;
    localparam logic [2:0] MC_MULH   = 3'b001;
    localparam logic [2:0] MC_MULHSU = 3'b010;
    localparam logic [2:0] MC_MULHU  = 3'b011;
    localparam logic [2:0] MC_DIV    = 3'b100;
    localparam logic [2:0] MC_DIVU   = 3'b101;
    localparam logic [2:0] MC_REM    = 3'b110;
    localparam logic [2:0] MC_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MC_IDLE      = 2'd0,
        MC_COMPUTING = 2'd1,
        MC_DONE      = 2'd2
    } mc_state_e;

    // All divide/remainder ops have Funct3[2] set
    function automatic logic mc_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // MUL is treated as unsigned: its low word does not depend on signedness
    function automatic logic mc_op1_signed(input logic [2:0] f3);
        return (f3 == MC_MULH) || (f3 == MC_MULHSU) || (f3 == MC_DIV) || (f3 == MC_REM);
    endfunction

    function automatic logic mc_op2_signed(input logic [2:0] f3);
        return (f3 == MC_MULH) || (f3 == MC_DIV) || (f3 == MC_REM);
    endfunction

endpackage

// File: rtl/mcycle_sign_fix.sv
// Combinational sign handling: operand magnitudes on entry, result negation on exit.
module mcycle_sign_fix
    import mcycle_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]         funct3_i,
    input  logic [WIDTH-1:0]   op1_i,
    input  logic [WIDTH-1:0]   op2_i,
    output logic [WIDTH-1:0]   abs1_o,
    output logic [WIDTH-1:0]   abs2_o,
    output logic               neg1_o,
    output logic               neg2_o,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   quot_i,
    input  logic [WIDTH-1:0]   rem_i,
    input  logic               fix_prod_i,
    input  logic               fix_quot_i,
    input  logic               fix_rem_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quot_o,
    output logic [WIDTH-1:0]   rem_o
);

    // Operand magnitudes according to the signedness of the selected op
    always_comb begin
        neg1_o = mc_op1_signed(funct3_i) & op1_i[WIDTH-1];
        neg2_o = mc_op2_signed(funct3_i) & op2_i[WIDTH-1];
        abs1_o = neg1_o ? -op1_i : op1_i;
        abs2_o = neg2_o ? -op2_i : op2_i;
    end

    // Two's-complement restore of the final magnitudes
    always_comb begin
        prod_o = fix_prod_i ? -prod_i : prod_i;
        quot_o = fix_quot_i ? -quot_i : quot_i;
        rem_o  = fix_rem_i  ? -rem_i  : rem_i;
    end

endmodule

// File: rtl/mcycle_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, WIDTH cycles per operation, stalling the pipeline via Busy.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result,
    output logic             Busy
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    mc_state_e            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2:0]           f3_q, f3_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;  // multiplicand or divisor magnitude
    logic                 neg1_q, neg1_d;
    logic                 neg2_q, neg2_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic [WIDTH-1:0]     abs1, abs2;
    logic                 neg1, neg2;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_step;
    logic [WIDTH:0]       div_shift, div_trial;
    logic [WIDTH-1:0]     quot_step, rem_step;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;
    logic                 fix_prod, fix_quot, fix_rem;

    // Quotient is left all-ones on divide-by-zero. The remainder keeps its
    // dividend-sign fix: negating |Operand1| reproduces Operand1 exactly.
    assign fix_prod = neg1_q ^ neg2_q;
    assign fix_quot = (neg1_q ^ neg2_q) & ~dz_q;
    assign fix_rem  = neg1_q;

    mcycle_sign_fix #(
        .WIDTH(WIDTH)
    ) u_sign_fix (
        .funct3_i  (Funct3),
        .op1_i     (Operand1),
        .op2_i     (Operand2),
        .abs1_o    (abs1),
        .abs2_o    (abs2),
        .neg1_o    (neg1),
        .neg2_o    (neg2),
        .prod_i    (prod_step),
        .quot_i    (quot_step),
        .rem_i     (rem_step),
        .fix_prod_i(fix_prod),
        .fix_quot_i(fix_quot),
        .fix_rem_i (fix_rem),
        .prod_o    (prod_fix),
        .quot_o    (quot_fix),
        .rem_o     (rem_fix)
    );

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, dvsr_q};
        prod_step = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]}
                              : {1'b0, prod_q[2*WIDTH-1:1]};
        div_shift = {rem_q, quot_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, dvsr_q};
        if (!div_trial[WIDTH]) begin
            rem_step  = div_trial[WIDTH-1:0];
            quot_step = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step  = div_shift[WIDTH-1:0];
            quot_step = {quot_q[WIDTH-2:0], 1'b0};
        end
    end

    // FSM next state, datapath updates and Busy
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        prod_d   = prod_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        dz_d     = dz_q;
        result_d = result_q;
        Busy     = 1'b0;
        unique case (state_q)
            MC_IDLE: begin
                Busy = Start;
                if (Start) begin
                    f3_d    = Funct3;
                    neg1_d  = neg1;
                    neg2_d  = neg2;
                    dvsr_d  = abs2;
                    dz_d    = (abs2 == '0);
                    prod_d  = {{WIDTH{1'b0}}, abs1};
                    quot_d  = abs1;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = MC_COMPUTING;
                end
            end
            MC_COMPUTING: begin
                Busy  = 1'b1;
                cnt_d = cnt_q + CntW'(1);
                if (mc_is_div(f3_q)) begin
                    quot_d = quot_step;
                    rem_d  = rem_step;
                end else begin
                    prod_d = prod_step;
                end
                if (cnt_q == CntLast) begin
                    state_d = MC_DONE;
                    case (f3_q)
                        MC_MUL:                        result_d = prod_fix[WIDTH-1:0];
                        MC_MULH, MC_MULHSU, MC_MULHU:  result_d = prod_fix[2*WIDTH-1:WIDTH];
                        MC_DIV, MC_DIVU:               result_d = quot_fix;
                        default:                       result_d = rem_fix;
                    endcase
                end
            end
            MC_DONE: begin
                // Start still reflects the instruction just completed
                state_d = MC_IDLE;
            end
            default: state_d = MC_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= MC_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            prod_q   <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            prod_q   <= prod_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end

    assign Result = result_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed RV32M cases plus random ops
// checked against an arithmetic reference model.
module tb_mcycle_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mcycle_unit #(
        .WIDTH(32)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .Start   (Start),
        .Funct3  (Funct3),
        .Operand1(Operand1),
        .Operand2(Operand2),
        .Result  (Result),
        .Busy    (Busy)
    );

    // Reference: plain 64-bit arithmetic from the RV32M definitions
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Moves to the next cycle (IDLE), issues an op and holds Start through DONE.
    // Operands are scrambled once computing starts. Returns in the DONE cycle.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int n;
        @(posedge CLK);
        #1;
        Funct3   = f3;
        Operand1 = a;
        Operand2 = b;
        Start    = 1'b1;
        #1;
        check({tag, " busy_at_start"}, 32'(Busy), 32'd1);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK);
            #1;
            Funct3   = 3'($urandom);
            Operand1 = $urandom;
            Operand2 = $urandom;
            if (Busy) n++;
            else break;
        end
        check({tag, " busy_cycles"}, 32'(n), 32'd33);
        check({tag, " result"}, Result, exp);
    endtask

    initial begin
        RESET    = 1'b1;
        Start    = 1'b0;
        Funct3   = 3'd0;
        Operand1 = 32'h0;
        Operand2 = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset busy", 32'(Busy), 32'd0);
        check("reset result", Result, 32'd0);
        RESET = 1'b0;

        // Directed cases, issued back to back
        do_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
        do_op(3'd5, 32'd100,       32'd7,         32'd14,        "divu_100_7");
        do_op(3'd7, 32'd100,       32'd7,         32'd2,         "remu_100_7");
        do_op(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_by0");
        do_op(3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "div_by0");
        do_op(3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "rem_by0");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "rem_ovf");

        // Start was held through DONE: the FSM must now be idle, not restarted
        @(posedge CLK);
        #1;
        Start = 1'b0;
        #1;
        check("no_restart busy", 32'(Busy), 32'd0);
        @(posedge CLK);
        #1;
        check("no_restart busy2", 32'(Busy), 32'd0);
        check("no_restart result_held", Result, 32'h0);

        // Random ops against the reference model
        for (int i = 0; i < 16; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            do_op(f3, a, b, ref_model(f3, a, b), $sformatf("rand%0d_f%0d", i, f3));
        end

        // Leave a nonzero result, then abort an op in computing cycle 10
        do_op(3'd0, 32'd5, 32'd6, 32'd30, "mul_5_6");
        @(posedge CLK);
        #1;
        Funct3   = 3'd0;
        Operand1 = 32'd9;
        Operand2 = 32'd9;
        Start    = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("abort computing", 32'(Busy), 32'd1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        Start = 1'b0;
        #1;
        check("abort busy", 32'(Busy), 32'd0);
        check("abort result", Result, 32'd0);
        @(posedge CLK);
        #1;
        check("abort idle", 32'(Busy), 32'd0);
        do_op(3'd0, 32'd3, 32'd4, 32'd12, "mul_3_4");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
